// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: producer latency type and the
// per-class latencies that decode assigns to id_lat.
package hazard_pkg;

    localparam int LAT_W_DFLT = 3;

    typedef logic [LAT_W_DFLT-1:0] lat_t;

    // Stall cycles a back-to-back consumer needs behind each producer class
    localparam lat_t LAT_ALU  = 3'd0;
    localparam lat_t LAT_LOAD = 3'd1;
    localparam lat_t LAT_MUL  = 3'd4;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: countdown of cycles until its register's value is
// available. Load has priority over the decrement.
module sb_counter
    import hazard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt,
    output logic             busy
);

    // Reload on issue, otherwise count down to zero and hold
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - LAT_W'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard detector and stall controller between ID and EX.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int LAT_W  = LAT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              bubble,
    output logic              issue,
`ifdef HAZARD_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       issue_count,
`endif
    output logic [NREG-1:0]   busy_vec
);

    // Table covers the whole address space so out-of-range indices read 0
    localparam int NADDR = 2 ** REG_AW;

    logic [LAT_W-1:0] cnt_tab [NADDR];
    logic             raw, waw, stall, rec_en;

    assign cnt_tab[0] = '0;
    assign busy_vec[0] = 1'b0;

    // x0 is never recorded; rec_en is already gated by flush through issue
    assign rec_en = issue & id_rd_we & (id_rd != '0);

    genvar g;
    generate
        for (g = 1; g < NADDR; g++) begin : g_reg
            if (g < NREG) begin : g_cnt
                sb_counter #(.LAT_W(LAT_W)) u_cnt (
                    .clk      (clk),
                    .rst      (rst),
                    .load     (rec_en && (id_rd == REG_AW'(g))),
                    .load_val (id_lat),
                    .cnt      (cnt_tab[g]),
                    .busy     (busy_vec[g])
                );
            end else begin : g_none
                assign cnt_tab[g] = '0;
            end
        end
    endgenerate

    // Hazard detection and stall/issue decisions from registered counters
    always_comb begin
        raw = (id_use_rs1 && cnt_tab[id_rs1] != '0) ||
              (id_use_rs2 && cnt_tab[id_rs2] != '0);
        // A younger write must not complete before an older pending one
        waw = id_rd_we && (id_rd != '0) && (cnt_tab[id_rd] > id_lat);
        stall      = id_valid & ~flush & (raw | waw);
        issue      = id_valid & ~flush & ~stall;
        pc_write   = ~stall;
        ifid_write = ~stall;
        bubble     = stall | flush | ~id_valid;
    end

`ifdef HAZARD_STATS_EN
    // Free-running stall and issue counters, wrapping modulo 2**32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            issue_count  <= '0;
        end else begin
            if (stall) stall_cycles <= stall_cycles + 32'd1;
            if (issue) issue_count  <= issue_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: cycle table of ID inputs with
// hand-derived expected outputs, checked through an expectation queue.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_rd_we, flush;
    logic [2:0]  id_lat;
    logic        pc_write, ifid_write, bubble, issue;
    logic [31:0] busy_vec;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, issue_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(32), .REG_AW(5), .LAT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_rd_we   (id_rd_we),
        .id_lat     (id_lat),
        .flush      (flush),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .bubble     (bubble),
        .issue      (issue),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .issue_count  (issue_count),
`endif
        .busy_vec   (busy_vec)
    );

    typedef struct {
        logic        rst, valid;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic [2:0]  lat;
        logic        fl;
        logic        pcw, bub, iss;
        logic [31:0] busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exq[$];

    function automatic vec_t mk(logic r, logic v, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd,
                                logic we, logic [2:0] lat, logic fl,
                                logic pcw, logic bub, logic iss, logic [31:0] busy);
        vec_t t;
        t.rst = r; t.valid = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.lat = lat; t.fl = fl;
        t.pcw = pcw; t.bub = bub; t.iss = iss; t.busy = busy;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.valid; id_rs1 = t.rs1; id_use_rs1 = t.u1;
        id_rs2 = t.rs2; id_use_rs2 = t.u2; id_rd = t.rd; id_rd_we = t.we;
        id_lat = t.lat; flush = t.fl;
    endtask

    task automatic check_pop(input string name);
        vec_t e;
        logic [35:0] got, exp;
        e = exq.pop_front();
        got = {pc_write, ifid_write, bubble, issue, busy_vec};
        exp = {e.pcw, e.pcw, e.bub, e.iss, e.busy};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: {pcw,ifidw,bub,iss,busy}=%h expected %h", name, got, exp);
        end
    endtask

    // One cycle: drive after the edge, record expectation, sample at negedge
    task automatic step(input vec_t t, input string name);
        @(posedge clk);
        #1;
        drive(t);
        exq.push_back(t);
        @(negedge clk);
        check_pop(name);
    endtask

    initial begin
        // Load-use on x5
        tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,1,0, 1,0,1, 32'h0));
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0,0, 0,1,0, 32'h20));
        tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0,0, 1,0,1, 32'h0));
        // Multi-cycle producer x7, consumer via rs2
        tbl.push_back(mk(0,1, 0,0, 0,0, 7,1,4,0, 1,0,1, 32'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1, 0,0, 7,1, 0,0,0,0, 0,1,0, 32'h80));
        tbl.push_back(mk(0,1, 0,0, 7,1, 0,0,0,0, 1,0,1, 32'h0));
        // x0 write is ignored, x0 reads never stall
        tbl.push_back(mk(0,1, 0,0, 0,0, 0,1,3,0, 1,0,1, 32'h0));
        tbl.push_back(mk(0,1, 0,1, 0,1, 0,0,0,0, 1,0,1, 32'h0));
        // Flushed producer records nothing
        tbl.push_back(mk(0,1, 0,0, 0,0, 9,1,3,1, 1,1,0, 32'h0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h0));
        // WAW on x8: lat 4 then lat 1
        tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,4,0, 1,0,1, 32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,1,0, 0,1,0, 32'h100));
        tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,1,0, 1,0,1, 32'h100));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h100));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h0));
        // Flush masks a pending RAW; decrement continues
        tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,2,0, 1,0,1, 32'h0));
        tbl.push_back(mk(0,1, 3,1, 0,0, 0,0,0,1, 1,1,0, 32'h8));
        tbl.push_back(mk(0,1, 3,1, 0,0, 0,0,0,0, 0,1,0, 32'h8));
        tbl.push_back(mk(0,1, 3,1, 0,0, 0,0,0,0, 1,0,1, 32'h0));
        // Zero latency never stalls
        tbl.push_back(mk(0,1, 0,0, 0,0, 4,1,0,0, 1,0,1, 32'h0));
        tbl.push_back(mk(0,1, 4,1, 0,0, 0,0,0,0, 1,0,1, 32'h0));
        // Reset mid-stall: stall persists in the reset cycle, drops after
        tbl.push_back(mk(0,1, 0,0, 0,0, 6,1,5,0, 1,0,1, 32'h0));
        tbl.push_back(mk(0,1, 6,1, 0,0, 0,0,0,0, 0,1,0, 32'h40));
        tbl.push_back(mk(1,1, 6,1, 0,0, 0,0,0,0, 0,1,0, 32'h40));
        tbl.push_back(mk(0,1, 6,1, 0,0, 0,0,0,0, 1,0,1, 32'h0));

        // Reset with random ID inputs, then release idle
        rst = 1'b1;
        id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom); id_rd = 5'($urandom);
        id_rd_we = 1'($urandom); id_lat = 3'($urandom); flush = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;
        drive(mk(0,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h0));
        exq.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h0));
        @(negedge clk);
        check_pop("reset");

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("row%0d", i));

        // Stats scenario: clean reset, then the multi-cycle sequence
        step(mk(1,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h0), "stats_rst");
        step(mk(0,1, 0,0, 0,0, 7,1,4,0, 1,0,1, 32'h0), "stats_prod");
        for (int i = 0; i < 4; i++)
            step(mk(0,1, 0,0, 7,1, 0,0,0,0, 0,1,0, 32'h80), "stats_stall");
        step(mk(0,1, 0,0, 7,1, 0,0,0,0, 1,0,1, 32'h0), "stats_cons");
        @(posedge clk);
        #1;
        drive(mk(0,0, 0,0, 0,0, 0,0,0,0, 1,1,0, 32'h0));
        @(negedge clk);
`ifdef HAZARD_STATS_EN
        tests++;
        if (stall_cycles !== 32'd4) begin
            fails++;
            $display("FAIL stall_cycles: got %0d expected 4", stall_cycles);
        end
        tests++;
        if (issue_count !== 32'd2) begin
            fails++;
            $display("FAIL issue_count: got %0d expected 2", issue_count);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and stall controller for the pipelined RISC-V core, replacing the fixed load-use detector between ID and EX. It keeps a per-register countdown scoreboard, so any producer latency can be handled, not only the single load-use case. Examples are loads, multi-cycle multiply/divide, and future long-latency units. It drives the PC write enable, the IF/ID write enable and the control-bubble select for the ID/EX control mux.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- REG_AW, 5, register address width; must satisfy 2**REG_AW >= NREG.
- LAT_W, 3, width of the latency field; maximum producer latency is 2**LAT_W-1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source register addresses.
- id_use_rs1, id_use_rs2  in  1  the instruction reads the corresponding source.
- id_rd  in  REG_AW  destination register address.
- id_rd_we  in  1  the instruction writes id_rd.
- id_lat  in  LAT_W  stall cycles a back-to-back consumer of id_rd needs (ALU 0, load 1, mul 4).
- flush  in  1  the ID instruction is killed this cycle (taken branch).
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID buffer write enable.
- bubble  out  1  selects zero controls into ID/EX.
- issue  out  1  the ID instruction advances to EX this cycle.
- busy_vec  out  NREG  bit r is set when cnt[r] != 0.

## Operation
- Storage: one LAT_W-bit counter cnt[r] for each r in 1..NREG-1. cnt[0] is constant 0.
- A raw hazard exists when (id_use_rs1 and cnt[id_rs1]!=0) or (id_use_rs2 and cnt[id_rs2]!=0).
- A WAW hazard exists when id_rd_we, id_rd!=0 and cnt[id_rd] > id_lat.
- stall = id_valid & !flush & (raw | waw).
- issue = id_valid & !flush & !stall.
- pc_write = ifid_write = !stall.
- bubble = stall | flush | !id_valid.
- Counter update at each clock edge, for every r:
  - If issue & id_rd_we & id_rd==r & r!=0, then cnt[r] <= id_lat.
  - Otherwise, if cnt[r]!=0, then cnt[r] <= cnt[r]-1.
  - Otherwise cnt[r] holds.
- When a new issue and a decrement target the same register in the same cycle, the new issue wins.
- A write to register 0 is never recorded, and a read of register 0 never stalls.
- If id_lat=0, the write leaves cnt at 0, so no stall is ever produced.
- When flush is active, no scoreboard write happens regardless of the other inputs; decrements continue.
- Address range: indices >= NREG read as counter 0 and are never written.

## Timing
- All outputs are combinational from the registered counters and the current ID inputs. There are no registered outputs apart from busy_vec, which is taken directly from the counters.
- A producer issued in cycle t with latency L gives cnt=L in cycle t+1, decrementing to 0 in cycle t+1+L.
- A consumer sitting in ID from t+1 therefore stalls exactly L cycles and issues in cycle t+1+L.
- Reset values:
  - All cnt are 0 and busy_vec is 0.
  - With id_valid=0: pc_write=1, ifid_write=1, bubble=1, issue=0.
- Reset asserted mid-stall clears all counters at the next edge. The stall drops in the following cycle.

## Configuration
- HAZARD_STATS_EN defined adds two outputs, stall_cycles and issue_count, both 32 bits.
  - Each counts cycles with stall=1 and issue=1 respectively.
  - Both clear on rst and wrap modulo 2**32.
- HAZARD_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package hazard_pkg holds:
  - the latency typedef lat_t, LAT_W bits;
  - constants LAT_ALU=0, LAT_LOAD=1 and LAT_MUL=4, also used by controlCPU decode.
- One sub-module, sb_counter: a single LAT_W countdown counter with load, load value, busy output and synchronous reset. It is instantiated NREG-1 times in a generate loop.

## Test plan
- Reset: drive rst for 2 cycles with a random ID input, then release with id_valid=0 -> busy_vec=0, pc_write=1, issue=0, bubble=1.
- Load-use: issue rd=x5, lat=1, then next cycle use rs1=x5 -> stall for 1 cycle, issue in the 2nd cycle, busy_vec[5] high for 1 cycle.
- Multi-cycle: issue rd=x7, lat=4, then use rs2=x7 -> exactly 4 stall cycles with pc_write=0 and ifid_write=0, then issue.
- x0 and flush: issue rd=x0, lat=3 -> no busy bit is set and the consumer of x0 never stalls. Issue rd=x9, lat=3 with flush=1 -> busy_vec[9] stays 0.
- WAW: issue rd=x8, lat=4, then rd=x8, lat=1 -> 3 stall cycles, after which cnt[8]=1 is reloaded with 1.
- Stats (HAZARD_STATS_EN): run the multi-cycle scenario -> stall_cycles=4, issue_count=2.
